// File: rtl/vram_arbiter.sv
// VRAM arbiter: the VDP owns every vdp_slot cycle; the aux port gets the free cycles
// for posted writes (small FIFO) and blocking reads that stay coherent with those writes.
module vram_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 8,
    parameter int WBUF_DEPTH = 4,
    parameter int STARVE_MAX = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          vdp_slot,
    input  logic                          vdp_we_n,
    input  logic                          vdp_oe_n,
    input  logic [ADDR_W-1:0]             vdp_addr,
    input  logic [DATA_W-1:0]             vdp_wdata,
    output logic [DATA_W-1:0]             vdp_rdata,
    input  logic                          aux_req,
    input  logic                          aux_we,
    input  logic [ADDR_W-1:0]             aux_addr,
    input  logic [DATA_W-1:0]             aux_wdata,
    output logic                          aux_ack,
    output logic [DATA_W-1:0]             aux_rdata,
    output logic                          aux_rvalid,
    output logic [$clog2(WBUF_DEPTH):0]   wbuf_level,
    output logic                          starve_err,
    output logic                          ram_we,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [DATA_W-1:0]             ram_din,
    input  logic [DATA_W-1:0]             ram_dout
);
    // state   | meaning
    // IDLE    | accepting aux requests
    // ISSUE   | aux read latched, waiting for a free (non-VDP) cycle
    // CAPTURE | RAM returns aux read data, aux_rvalid pulses
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_CAPTURE} rd_state_t;

    localparam int IDX_W = $clog2(WBUF_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    rd_state_t             state, state_nxt;
    logic [ADDR_W-1:0]     wb_addr [WBUF_DEPTH];
    logic [DATA_W-1:0]     wb_data [WBUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic                  empty, full, push, pop, rd_ack, issue;
    logic [ADDR_W-1:0]     rd_addr_q;
    logic [DATA_W-1:0]     aux_rdata_q, vdp_rdata_q;
    logic                  vdp_own_d;
    logic [CNT_W-1:0]      starve_cnt, cnt_nxt;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                        (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign wbuf_level = wr_ptr - rd_ptr;
    // Gating with rst_n keeps the RAM untouched during the reset cycle itself.
    assign push       = rst_n & aux_req & aux_we & ~full & (state == ST_IDLE);
    assign pop        = rst_n & ~vdp_slot & ~empty;
    assign aux_ack    = push | rd_ack;
    assign aux_rvalid = rst_n & (state == ST_CAPTURE);
    assign aux_rdata  = aux_rvalid ? ram_dout : aux_rdata_q;
    assign vdp_rdata  = vdp_own_d ? ram_dout : vdp_rdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_ack    = 1'b0;
        issue     = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_din   = '0;
        case (state)
            ST_IDLE: begin
                if (rst_n && aux_req && !aux_we && empty) begin
                    rd_ack    = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (rst_n && !vdp_slot) begin
                    issue     = 1'b1;
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
        // The FIFO is always empty outside IDLE, so pop and issue never collide.
        if (vdp_slot) begin
            ram_addr = vdp_addr;
            ram_din  = vdp_wdata;
            ram_we   = ~vdp_we_n;
        end else if (pop) begin
            ram_we   = 1'b1;
            ram_addr = wb_addr[rd_ptr[IDX_W-1:0]];
            ram_din  = wb_data[rd_ptr[IDX_W-1:0]];
        end else if (issue) begin
            ram_addr = rd_addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr[wr_ptr[IDX_W-1:0]] <= aux_addr;
            wb_data[wr_ptr[IDX_W-1:0]] <= aux_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rd_addr_q   <= '0;
            aux_rdata_q <= '0;
            vdp_rdata_q <= '0;
            vdp_own_d   <= 1'b0;
        end else begin
            if (push)   wr_ptr    <= wr_ptr + 1'b1;
            if (pop)    rd_ptr    <= rd_ptr + 1'b1;
            if (rd_ack) rd_addr_q <= aux_addr;
            if (state == ST_CAPTURE) aux_rdata_q <= ram_dout;
            if (vdp_own_d) vdp_rdata_q <= ram_dout;
            vdp_own_d <= vdp_slot & ~vdp_oe_n;
        end
    end

    always_comb begin
        cnt_nxt = starve_cnt;
        if (!vdp_slot) begin
            cnt_nxt = '0;
        end else if ((!empty || state == ST_ISSUE) && starve_cnt != CNT_W'(STARVE_MAX)) begin
            cnt_nxt = starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            starve_err <= 1'b0;
        end else begin
            starve_cnt <= cnt_nxt;
            if (cnt_nxt == CNT_W'(STARVE_MAX)) starve_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 32K x 8 synchronous RAM model.
module tb_vram_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        vdp_slot, vdp_we_n, vdp_oe_n;
    logic [14:0] vdp_addr;
    logic [7:0]  vdp_wdata, vdp_rdata;
    logic        aux_req, aux_we;
    logic [14:0] aux_addr;
    logic [7:0]  aux_wdata, aux_rdata;
    logic        aux_ack, aux_rvalid;
    logic [2:0]  wbuf_level;
    logic        starve_err, ram_we;
    logic [14:0] ram_addr;
    logic [7:0]  ram_din, ram_dout;
    logic [7:0]  mem [0:32767];

    int checks = 0;
    int failures = 0;

    vram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .vdp_slot(vdp_slot), .vdp_we_n(vdp_we_n), .vdp_oe_n(vdp_oe_n),
        .vdp_addr(vdp_addr), .vdp_wdata(vdp_wdata), .vdp_rdata(vdp_rdata),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_ack(aux_ack), .aux_rdata(aux_rdata), .aux_rvalid(aux_rvalid),
        .wbuf_level(wbuf_level), .starve_err(starve_err),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    typedef struct {
        logic        slot, we_n, oe_n;
        logic [14:0] vaddr;
        logic [7:0]  vwdata;
        logic        req, awe;
        logic [14:0] aaddr;
        logic [7:0]  awdata;
        logic        e_ack, e_we;
        logic [14:0] e_addr;
        logic [7:0]  e_din;
        logic [2:0]  e_lvl;
        logic [7:0]  e_vrd;
        logic        e_rv;
        logic [7:0]  e_ard;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        vdp_slot = 1'b0; vdp_we_n = 1'b1; vdp_oe_n = 1'b1;
        vdp_addr = '0;   vdp_wdata = '0;
        aux_req = 1'b0;  aux_we = 1'b0; aux_addr = '0; aux_wdata = '0;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (2) cyc();
        rst_n = 1'b1;
    endtask

    task automatic aux_drive(input logic req, input logic we, input logic [14:0] a, input logic [7:0] d);
        aux_req = req; aux_we = we; aux_addr = a; aux_wdata = d;
    endtask

    initial begin
        int pulses;
        logic [7:0] got;

        vecs[0] = '{1,0,1,15'h1234,8'hA5, 0,0,15'h0,8'h0,  0,1,15'h1234,8'hA5, 0,8'h00,0,8'h00};
        vecs[1] = '{1,1,0,15'h1234,8'h00, 0,0,15'h0,8'h0,  0,0,15'h1234,8'h00, 0,8'h00,0,8'h00};
        vecs[2] = '{1,1,1,15'h0555,8'h00, 1,1,15'h0100,8'h11, 1,0,15'h0555,8'h00, 0,8'hA5,0,8'h00};
        vecs[3] = '{1,1,1,15'h0555,8'h00, 0,0,15'h0,8'h0,  0,0,15'h0555,8'h00, 1,8'hA5,0,8'h00};
        vecs[4] = '{0,1,1,15'h0555,8'h00, 0,0,15'h0,8'h0,  0,1,15'h0100,8'h11, 1,8'hA5,0,8'h00};
        vecs[5] = '{0,1,1,15'h0555,8'h00, 1,0,15'h0100,8'h0, 1,0,15'h0000,8'h00, 0,8'hA5,0,8'h00};
        vecs[6] = '{0,1,1,15'h0555,8'h00, 0,0,15'h0,8'h0,  0,0,15'h0100,8'h00, 0,8'hA5,0,8'h00};
        vecs[7] = '{1,1,1,15'h0200,8'h00, 1,0,15'h0100,8'h0, 0,0,15'h0200,8'h00, 0,8'hA5,1,8'h11};
        vecs[8] = '{1,1,1,15'h0200,8'h00, 1,0,15'h0100,8'h0, 1,0,15'h0200,8'h00, 0,8'hA5,0,8'h11};

        rst_n = 1'b0;
        drive_idle();
        do_reset();

        @(negedge clk);
        chk("rst_ack", aux_ack, 0);
        chk("rst_rvalid", aux_rvalid, 0);
        chk("rst_rdata", aux_rdata, 0);
        chk("rst_vdp_rdata", vdp_rdata, 0);
        chk("rst_starve", starve_err, 0);
        chk("rst_level", wbuf_level, 0);
        cyc();

        for (int i = 0; i < 9; i++) begin
            vdp_slot = vecs[i].slot; vdp_we_n = vecs[i].we_n; vdp_oe_n = vecs[i].oe_n;
            vdp_addr = vecs[i].vaddr; vdp_wdata = vecs[i].vwdata;
            aux_drive(vecs[i].req, vecs[i].awe, vecs[i].aaddr, vecs[i].awdata);
            @(negedge clk);
            chk($sformatf("v%0d_ack", i), aux_ack, vecs[i].e_ack);
            chk($sformatf("v%0d_ram_we", i), ram_we, vecs[i].e_we);
            chk($sformatf("v%0d_ram_addr", i), ram_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_ram_din", i), ram_din, vecs[i].e_din);
            chk($sformatf("v%0d_level", i), wbuf_level, vecs[i].e_lvl);
            chk($sformatf("v%0d_vdp_rdata", i), vdp_rdata, vecs[i].e_vrd);
            chk($sformatf("v%0d_rvalid", i), aux_rvalid, vecs[i].e_rv);
            chk($sformatf("v%0d_aux_rdata", i), aux_rdata, vecs[i].e_ard);
            cyc();
        end

        // FIFO fill, full back-pressure, ordered drain
        do_reset();
        vdp_slot = 1'b1;
        for (int i = 0; i < 4; i++) begin
            aux_drive(1, 1, 15'(i), 8'(8'hC0 + i));
            @(negedge clk);
            chk($sformatf("fill%0d_ack", i), aux_ack, 1);
            cyc();
        end
        aux_drive(1, 1, 15'd4, 8'hC4);
        @(negedge clk);
        chk("full_ack", aux_ack, 0);
        chk("full_level", wbuf_level, 4);
        cyc();
        vdp_slot = 1'b0;
        @(negedge clk);
        chk("full_pop_ack", aux_ack, 0);
        chk("full_pop_addr", ram_addr, 0);
        cyc();
        @(negedge clk);
        chk("push_pop_ack", aux_ack, 1);
        cyc();
        aux_drive(0, 0, 0, 0);
        @(negedge clk);
        chk("push_pop_level", wbuf_level, 3);
        for (int i = 0; i < 10 && wbuf_level != 0; i++) cyc();
        chk("drain_level", wbuf_level, 0);
        cyc();
        for (int i = 0; i < 5; i++) chk($sformatf("drain_mem%0d", i), mem[i], 8'hC0 + i);

        // read-after-write coherence
        do_reset();
        vdp_slot = 1'b1;
        aux_drive(1, 1, 15'h7FFF, 8'h3C);
        @(negedge clk); chk("raw_wr_ack", aux_ack, 1); cyc();
        aux_drive(1, 0, 15'h7FFF, 8'h00);
        @(negedge clk); chk("raw_rd_blocked", aux_ack, 0); cyc();
        vdp_slot = 1'b0;
        @(negedge clk); chk("raw_rd_blocked_drain", aux_ack, 0); cyc();
        @(negedge clk);
        chk("raw_rd_ack", aux_ack, 1);
        chk("raw_level", wbuf_level, 0);
        cyc();
        aux_drive(0, 0, 0, 0);
        pulses = 0; got = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (aux_rvalid) begin pulses++; got = aux_rdata; end
            cyc();
        end
        chk("raw_pulses", pulses, 1);
        chk("raw_rdata", got, 8'h3C);

        // read held off by VDP slots
        do_reset();
        vdp_slot = 1'b1; vdp_we_n = 1'b0; vdp_addr = 15'h0AAA; vdp_wdata = 8'h5E;
        cyc();
        vdp_slot = 1'b0; vdp_we_n = 1'b1;
        aux_drive(1, 0, 15'h0AAA, 8'h00);
        @(negedge clk); chk("hold_ack", aux_ack, 1); cyc();
        aux_drive(0, 0, 0, 0);
        vdp_slot = 1'b1; vdp_addr = 15'h1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_addr", i), ram_addr, 15'h1111);
            chk($sformatf("hold%0d_rvalid", i), aux_rvalid, 0);
            cyc();
        end
        vdp_slot = 1'b0;
        @(negedge clk);
        chk("issue_addr", ram_addr, 15'h0AAA);
        chk("issue_we", ram_we, 0);
        cyc();
        vdp_slot = 1'b1;
        @(negedge clk);
        chk("capture_rvalid", aux_rvalid, 1);
        chk("capture_rdata", aux_rdata, 8'h5E);
        cyc();
        @(negedge clk);
        chk("capture_one_pulse", aux_rvalid, 0);
        chk("capture_rdata_hold", aux_rdata, 8'h5E);

        // starvation
        do_reset();
        vdp_slot = 1'b1;
        aux_drive(1, 1, 15'h0050, 8'h77);
        cyc();
        aux_drive(0, 0, 0, 0);
        repeat (62) cyc();
        @(posedge clk); #1;
        chk("starve_63", starve_err, 0);
        cyc();
        chk("starve_64", starve_err, 1);
        vdp_slot = 1'b0;
        repeat (3) cyc();
        chk("starve_drained_level", wbuf_level, 0);
        chk("starve_sticky", starve_err, 1);
        do_reset();
        @(negedge clk);
        chk("starve_cleared", starve_err, 0);

        // reset discards posted writes
        vdp_slot = 1'b1; vdp_we_n = 1'b0; vdp_addr = 15'h0060; vdp_wdata = 8'h00; cyc();
        vdp_addr = 15'h0061; cyc();
        vdp_we_n = 1'b1;
        aux_drive(1, 1, 15'h0060, 8'h99); cyc();
        aux_drive(1, 1, 15'h0061, 8'h99);
        @(negedge clk); chk("abort_level_pre", wbuf_level, 1); cyc();
        aux_drive(0, 0, 0, 0);
        vdp_slot = 1'b0; rst_n = 1'b0;
        @(negedge clk); chk("abort_ram_we", ram_we, 0); cyc();
        @(negedge clk);
        chk("abort_level", wbuf_level, 0);
        chk("abort_ack", aux_ack, 0);
        chk("abort_ram_addr", ram_addr, 0);
        cyc();
        rst_n = 1'b1;
        repeat (3) cyc();
        chk("abort_mem60", mem[15'h0060], 8'h00);
        chk("abort_mem61", mem[15'h0061], 8'h00);

        // reset aborts a read in CAPTURE
        aux_drive(1, 0, 15'h0AAA, 8'h00);
        @(negedge clk); chk("abort_rd_ack", aux_ack, 1); cyc();
        aux_drive(0, 0, 0, 0);
        cyc();
        rst_n = 1'b0;
        @(negedge clk); chk("abort_rd_rvalid", aux_rvalid, 0); cyc();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (aux_rvalid) pulses++;
            cyc();
        end
        chk("abort_rd_no_pulse", pulses, 0);
        chk("abort_rd_rdata", aux_rdata, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
